// File: rtl/cache_controller_pkg.sv
// Shared constants for the direct-mapped cache controller: default geometry,
// address-slicing positions and the FSM state encoding.
package cache_controller_pkg;

    localparam int CC_ADDR_W   = 32;
    localparam int CC_OFFSET_W = 2;
    localparam int CC_IDX_W    = 5;
    localparam int CC_DATA_W   = 32;
    localparam int CC_TAG_W    = CC_ADDR_W - CC_IDX_W - CC_OFFSET_W;

    // Bit positions of the index and tag fields in a byte address.
    localparam int CC_IDX_LSB = CC_OFFSET_W;
    localparam int CC_IDX_MSB = CC_IDX_W + CC_OFFSET_W - 1;
    localparam int CC_TAG_LSB = CC_IDX_W + CC_OFFSET_W;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_COMPARE   = 2'd1;
    localparam logic [1:0] ST_WRITEBACK = 2'd2;
    localparam logic [1:0] ST_ALLOCATE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        COMPARE   = ST_COMPARE,
        WRITEBACK = ST_WRITEBACK,
        ALLOCATE  = ST_ALLOCATE
    } state_e;

endpackage

// File: rtl/cache_controller_tag_memory.sv
// Per-line tag store with valid/dirty flags for the direct-mapped cache.
// Read is combinational on idx_i; fill and set-dirty update on the rising edge.
module cache_tag_memory
    import cache_controller_pkg::*;
#(
    parameter int IDX_W = CC_IDX_W,
    parameter int TAG_W = CC_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             fill_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic             set_dirty_i,
    output logic [TAG_W+1:0] line_o
);

    localparam int LINES = 1 << IDX_W;

    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;

    // NOTE: the tag array has no reset; a cleared valid bit makes its contents irrelevant.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[idx_i] <= fill_tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (set_dirty_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    assign line_o = {valid_q[idx_i], dirty_q[idx_i], tag_q[idx_i]};

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller (one word per line).
// Owns tag/valid/dirty state and drives the write side of the external data RAM.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int ADDR_W   = CC_ADDR_W,
    parameter int OFFSET_W = CC_OFFSET_W,
    parameter int IDX_W    = CC_IDX_W,
    parameter int DATA_W   = CC_DATA_W,
    parameter int TAG_W    = ADDR_W - IDX_W - OFFSET_W
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              dmem_we,
    output logic [IDX_W-1:0]  dmem_idx,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int TAG_LSB = IDX_W + OFFSET_W;

    state_e            state_q, state_d;
    logic              we_q;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;

    logic [TAG_W+1:0]  line;
    logic              line_valid, line_dirty, hit;
    logic [TAG_W-1:0]  line_tag;
    logic              fill, set_dirty;
    logic              unused_offset;

    assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

    cache_tag_memory #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk         (iCLK),
        .rst_n       (iRST_N),
        .idx_i       (idx_q),
        .fill_i      (fill),
        .fill_tag_i  (tag_q),
        .set_dirty_i (set_dirty),
        .line_o      (line)
    );

    assign {line_valid, line_dirty, line_tag} = line;
    assign hit = line_valid && (line_tag == tag_q);

    // The request is captured once in IDLE; CPU inputs are don't-care afterwards.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            tag_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cpu_req) begin
                we_q    <= cpu_we;
                tag_q   <= cpu_addr[ADDR_W-1:TAG_LSB];
                idx_q   <= cpu_addr[TAG_LSB-1:OFFSET_W];
                wdata_q <= cpu_wdata;
            end
        end
    end

    assign dmem_idx = (state_q == IDLE) ? cpu_addr[TAG_LSB-1:OFFSET_W] : idx_q;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d    = state_q;
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        dmem_we    = 1'b0;
        dmem_wdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill       = 1'b0;
        set_dirty  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) state_d = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    state_d   = IDLE;
                    if (we_q) begin
                        dmem_we    = 1'b1;
                        dmem_wdata = wdata_q;
                        set_dirty  = 1'b1;
                    end else begin
                        cpu_rdata = dmem_rdata;
                    end
                end else if (line_valid && line_dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {line_tag, idx_q, {OFFSET_W{1'b0}}};
                mem_wdata = dmem_rdata;
                if (mem_ack) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, idx_q, {OFFSET_W{1'b0}}};
                if (mem_ack) begin
                    dmem_we    = 1'b1;
                    dmem_wdata = mem_rdata;
                    fill       = 1'b1;
                    state_d    = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: directed accesses push expected CPU and
// main-memory transactions; monitors pop and compare as the DUT presents them.
module tb_cache_controller;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        dmem_we;
    logic [4:0]  dmem_idx;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
    } cpu_txn_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

    cpu_txn_t    cpu_q[$];
    mem_txn_t    mem_q[$];
    logic [31:0] dmem [32];
    logic [31:0] mainmem [logic [31:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int ack_delay = 0;
    bit spurious = 1'b0;

    always #5 iCLK = ~iCLK;

    cache_controller dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .dmem_we    (dmem_we),
        .dmem_idx   (dmem_idx),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Cache data RAM: combinational read, synchronous write.
    always @(posedge iCLK) if (dmem_we) dmem[dmem_idx] <= dmem_wdata;
    assign dmem_rdata = dmem[dmem_idx];

    // CPU-side monitor.
    always @(negedge iCLK) begin
        if (iRST_N && cpu_ready) begin
            if (cpu_q.size() == 0) begin
                check("cpu_ready_expected", cpu_q.size(), 1);
            end else begin
                cpu_txn_t e;
                e = cpu_q.pop_front();
                if (e.is_load) check("cpu_rdata", cpu_rdata, e.data);
            end
        end
    end

    // Main-memory model and monitor with programmable ack delay.
    bit          busy = 1'b0;
    bit          unstable = 1'b0;
    int          cnt = 0;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;

    always @(negedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            busy    = 1'b0;
            mem_ack = 1'b0;
        end else begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                busy    = 1'b0;
            end
            if (mem_req && !busy) begin
                if (mem_q.size() == 0) begin
                    check("mem_req_expected", mem_q.size(), 1);
                end else begin
                    mem_txn_t e;
                    e = mem_q.pop_front();
                    check("mem_we", mem_we, e.we);
                    check("mem_addr", mem_addr, e.addr);
                    if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                end
                r_we = mem_we; r_addr = mem_addr; r_wdata = mem_wdata;
                busy = 1'b1; unstable = 1'b0; cnt = ack_delay;
            end else if (busy) begin
                if (!mem_req || mem_we !== r_we || mem_addr !== r_addr || mem_wdata !== r_wdata)
                    unstable = 1'b1;
            end else if (spurious) begin
                mem_ack  = 1'b1;
                spurious = 1'b0;
            end
            if (busy) begin
                if (cnt == 0) begin
                    check("mem_stable", unstable, 0);
                    mem_ack = 1'b1;
                    if (r_we) mainmem[r_addr] = r_wdata;
                    else mem_rdata = mainmem.exists(r_addr) ? mainmem[r_addr] : ~r_addr;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Issue one access at a negedge and check its latency in cycles from acceptance.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input int exp_lat, input bit hold);
        int cyc = 0;
        cpu_q.push_back('{is_load: !we, data: exp_data});
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        do begin
            @(negedge iCLK);
            cyc++;
        end while (!cpu_ready && cyc < 100);
        check("latency", cyc, exp_lat);
        if (!hold) begin
            cpu_req = 1'b0;
            @(negedge iCLK);
        end
    endtask

    task automatic expect_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        mem_q.push_back('{we: we, addr: addr, wdata: wdata});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 32; i++) dmem[i] = '0;
        mainmem[32'h40] = 32'hDEAD_BEEF;
        mainmem[32'hC0] = 32'hCAFE_F00D;

        #12;
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dmem_we",   dmem_we,   0);
        check("rst_mem_req",   mem_req,   0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);

        // Cold load miss, then a hit.
        ack_delay = 1;
        expect_mem(1'b0, 32'h40, 32'h0);
        access(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 4, 1'b0);
        access(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);

        // Store hit marks the line dirty; reload sees the new value.
        access(1'b1, 32'h40, 32'h1234_5678, 32'h0, 1, 1'b0);
        access(1'b0, 32'h40, 32'h0, 32'h1234_5678, 1, 1'b0);

        // Dirty conflict: write-back of 0x40 then fill of 0xC0, both acks delayed 7.
        ack_delay = 7;
        expect_mem(1'b1, 32'h40, 32'h1234_5678);
        expect_mem(1'b0, 32'hC0, 32'h0);
        access(1'b0, 32'hC0, 32'h0, 32'hCAFE_F00D, 18, 1'b0);

        // Clean conflict: straight to fill; memory now holds the written-back word.
        ack_delay = 0;
        expect_mem(1'b0, 32'h40, 32'h0);
        access(1'b0, 32'h40, 32'h0, 32'h1234_5678, 3, 1'b0);

        // Back-to-back hits with cpu_req held high.
        access(1'b0, 32'h40, 32'h0, 32'h1234_5678, 1, 1'b1);
        access(1'b0, 32'h40, 32'h0, 32'h1234_5678, 2, 1'b0);

        // Stray ack while idle must be ignored.
        spurious = 1'b1;
        repeat (3) @(negedge iCLK);

        // Store miss allocates then writes.
        expect_mem(1'b0, 32'h80, 32'h0);
        access(1'b1, 32'h80, 32'hA5A5_0001, 32'h0, 3, 1'b0);
        access(1'b0, 32'h80, 32'h0, 32'hA5A5_0001, 1, 1'b0);

        // Reset during ALLOCATE.
        ack_delay = 20;
        expect_mem(1'b0, 32'h208, 32'h0);
        cpu_we = 1'b0; cpu_addr = 32'h208; cpu_req = 1'b1;
        cyc = 0;
        do begin
            @(negedge iCLK);
            cyc++;
        end while (!mem_req && cyc < 20);
        check("rst_alloc_reached", mem_req, 1);
        #3 iRST_N = 1'b0;
        #1;
        check("midrst_mem_req",   mem_req,   0);
        check("midrst_cpu_ready", cpu_ready, 0);
        cpu_req = 1'b0;
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);

        // After reset every line misses again; the dirty store to 0x80 was discarded.
        ack_delay = 0;
        expect_mem(1'b0, 32'h208, 32'h0);
        access(1'b0, 32'h208, 32'h0, ~32'h208, 3, 1'b0);
        expect_mem(1'b0, 32'h80, 32'h0);
        access(1'b0, 32'h80, 32'h0, ~32'h80, 3, 1'b0);

        repeat (3) @(negedge iCLK);
        check("cpu_q_drained", cpu_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-back, write-allocate cache controller for the RV32I data path. Sits between the CPU load/store unit and main memory. Owns the tag/valid/dirty store and drives the write side of the cache data memory, reading that memory's combinational output. One block equals one 32-bit word.

## Interface

Parameters
- ADDR_W, 32: byte address width.
- OFFSET_W, 2: byte-offset bits; ignored for indexing.
- IDX_W, 5: index bits; 32 lines.
- DATA_W, 32: word width.
- TAG_W, ADDR_W-IDX_W-OFFSET_W: tag width (derived).

Ports
- iCLK  in  1  clock; all state updates on the rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- dmem_we  out  1  data-memory write enable.
- dmem_idx  out  IDX_W  data-memory line index.
- dmem_wdata  out  DATA_W  data-memory write data.
- dmem_rdata  in  DATA_W  data-memory combinational read of dmem_idx.
- mem_req  out  1  main-memory request; held until mem_ack.
- mem_we  out  1  1 = write-back, 0 = fill.
- mem_addr  out  ADDR_W  word-aligned address; low OFFSET_W bits are 0.
- mem_wdata  out  DATA_W  write-back data.
- mem_rdata  in  DATA_W  fill data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion from main memory.

## Operation

- Address split: tag = addr[ADDR_W-1:IDX_W+OFFSET_W]; idx = addr[IDX_W+OFFSET_W-1:OFFSET_W].
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: on cpu_req, latch cpu_we, cpu_addr and cpu_wdata, then go to COMPARE. CPU inputs are ignored after the latch.
- COMPARE: hit = valid[idx] && tag[idx]==latched tag.
  - Load hit: cpu_rdata=dmem_rdata, cpu_ready=1, then IDLE.
  - Store hit: dmem_we=1, dmem_wdata=latched wdata, dirty[idx]<=1, cpu_ready=1, then IDLE.
  - Miss with the line valid and dirty: go to WRITEBACK.
  - Other misses: go to ALLOCATE.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={tag[idx], idx, 0}, mem_wdata=dmem_rdata. On mem_ack, go to ALLOCATE.
- ALLOCATE: mem_req=1, mem_we=0, mem_addr={latched tag, idx, 0}.
  - On mem_ack: dmem_we=1, dmem_wdata=mem_rdata, tag[idx]<=latched tag, valid<=1, dirty<=0, then COMPARE (re-check, which now hits).
- dmem_idx always equals the latched idx. In IDLE it equals cpu_addr idx.
- No partial-word stores; byte/halfword merging is upstream.

## Timing

- Reset (asynchronous): state=IDLE; all valid and dirty bits 0; cpu_ready, cpu_rdata, dmem_we, mem_req, mem_we, mem_addr and mem_wdata are 0.
- Hit latency: request accepted at edge N; cpu_ready is high in cycle N+1.
- Clean miss: 2 cycles + fill wait + 1. Dirty miss adds the write-back wait.
- mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the mem_ack cycle inclusive. They drop the cycle after the ack.
- mem_ack while mem_req=0 is ignored.
- cpu_req held high after cpu_ready: the next access is accepted at the edge following the cpu_ready cycle. Back-to-back hits complete every 2 cycles.
- Reset mid-miss: abandon immediately. mem_req drops asynchronously and no tag update occurs.

## Structure

- A shared package holds the state encoding (2-bit localparams) and the tag/index slicing helpers as constants derived from ADDR_W, OFFSET_W and IDX_W.
- Sub-module cache_tag_memory: a TAG_W+2-bit-wide array with per-line valid/dirty. Async reset clears valid/dirty; tags are not reset.
- The FSM and datapath muxing live in cache_controller.

## Test plan

- Reset, then load 0x0000_0040 -> ALLOCATE with mem_addr=0x40; mem_rdata=0xDEADBEEF; cpu_ready with cpu_rdata=0xDEADBEEF; a repeat load hits in 2 cycles with no mem_req.
- Store 0x1234_5678 to 0x40 (hit) -> dmem_we=1, no mem_req; a later load of 0x40 returns 0x12345678.
- Load 0x0000_00C0 (same idx, different tag) while line 0x40 is dirty -> WRITEBACK with mem_addr=0x40 and mem_wdata=0x12345678, then ALLOCATE with mem_addr=0xC0.
- Same conflict with a clean line -> no WRITEBACK; straight to ALLOCATE.
- Delay mem_ack by 0, 1 and 7 cycles -> mem_* outputs are stable throughout and a single cpu_ready is produced.
- Assert iRST_N=0 during ALLOCATE -> mem_req=0 immediately; after release, a load of the same address misses again.
